// File: rtl/branch_pred_pkg.sv
// Shared definitions for the branch predictor slice.
// Provides the default table size, the 2-bit saturating counter encoding,
// the RV32 control-flow opcodes that feed the update port, and a helper
// that turns a counter state into a taken/not-taken prediction.
package branch_pred_pkg;

    localparam int unsigned IDX_W_DEF = 4;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } ctr_e;

    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    function automatic logic ctr_taken(input ctr_e c);
        return (c == WT) || (c == ST);
    endfunction

endpackage

// File: rtl/sat_counter2.sv
// 2-bit saturating counter next-state logic.
// Ports:
//   state_i - current counter state
//   taken_i - resolved outcome (1 = taken)
//   next_o  - counter state after applying the outcome, saturating at SNT/ST
module sat_counter2
    import branch_pred_pkg::*;
(
    input  ctr_e state_i,
    input  logic taken_i,
    output ctr_e next_o
);

    always_comb begin
        next_o = state_i;
        if (taken_i) begin
            case (state_i)
                SNT:     next_o = WNT;
                WNT:     next_o = WT;
                WT:      next_o = ST;
                default: next_o = ST;
            endcase
        end else begin
            case (state_i)
                ST:      next_o = WT;
                WT:      next_o = WNT;
                WNT:     next_o = SNT;
                default: next_o = SNT;
            endcase
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with 2-bit saturating direction counters.
// Ports:
//   i_clk, i_rst          - clock, asynchronous active-high reset
//   i_pc_if               - fetch PC to predict
//   o_pred_taken/target   - combinational prediction and next fetch PC
//   i_upd_*               - resolved control-flow instruction from MEM
//   o_mispredict          - flush/redirect request for the resolved instruction
//   o_redirect_pc         - correct next PC for the resolved instruction
//   o_br_cnt/o_miss_cnt   - saturating update / misprediction counters
module branch_predictor
    import branch_pred_pkg::*;
#(
    parameter int unsigned IDX_W = IDX_W_DEF
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [31:0] i_pc_if,
    output logic        o_pred_taken,
    output logic [31:0] o_pred_target,
    input  logic        i_upd_valid,
    input  logic [31:0] i_upd_pc,
    input  logic        i_upd_taken,
    input  logic [31:0] i_upd_target,
    input  logic        i_upd_pred_taken,
    input  logic [31:0] i_upd_pred_target,
    output logic        o_mispredict,
    output logic [31:0] o_redirect_pc,
    output logic [15:0] o_br_cnt,
    output logic [15:0] o_miss_cnt
);

    localparam int unsigned N     = 1 << IDX_W;
    localparam int unsigned TAG_W = 32 - IDX_W - 2;

    // Table kept in flops so the asynchronous reset reaches every entry.
    logic              valid_q [N];
    logic [TAG_W-1:0]  tag_q   [N];
    logic [31:0]       tgt_q   [N];
    ctr_e              ctr_q   [N];

    logic [IDX_W-1:0]  if_idx, upd_idx;
    logic [TAG_W-1:0]  if_tag, upd_tag;
    logic              if_hit, upd_hit;
    ctr_e              upd_ctr_next;

    logic              wr_en;
    logic [31:0]       wr_tgt_d;
    ctr_e              wr_ctr_d;

    logic [15:0]       br_cnt_q, br_cnt_d;
    logic [15:0]       miss_cnt_q, miss_cnt_d;

    assign if_idx  = i_pc_if[IDX_W+1:2];
    assign if_tag  = i_pc_if[31:IDX_W+2];
    assign upd_idx = i_upd_pc[IDX_W+1:2];
    assign upd_tag = i_upd_pc[31:IDX_W+2];

    // Reads see the registered table, so a same-cycle update to the same
    // index is only visible from the following cycle.
    assign if_hit  = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
    assign upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);

    assign o_pred_taken  = if_hit && ctr_taken(ctr_q[if_idx]);
    assign o_pred_target = o_pred_taken ? tgt_q[if_idx] : i_pc_if + 32'd4;

    assign o_mispredict  = i_upd_valid &&
                           ((i_upd_taken != i_upd_pred_taken) ||
                            (i_upd_taken && i_upd_pred_taken &&
                             (i_upd_target != i_upd_pred_target)));
    assign o_redirect_pc = i_upd_taken ? i_upd_target : i_upd_pc + 32'd4;

    sat_counter2 u_sat_counter2 (
        .state_i (ctr_q[upd_idx]),
        .taken_i (i_upd_taken),
        .next_o  (upd_ctr_next)
    );

    always_comb begin
        wr_en    = 1'b0;
        wr_tgt_d = i_upd_target;
        wr_ctr_d = upd_ctr_next;
        if (i_upd_valid) begin
            if (upd_hit) begin
                wr_en = 1'b1;
                if (!i_upd_taken) begin
                    wr_tgt_d = tgt_q[upd_idx];
                end
            end else if (i_upd_taken) begin
                wr_en    = 1'b1;
                wr_ctr_d = WT;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int unsigned i = 0; i < N; i++) begin
                valid_q[i] <= 1'b0;
                tag_q[i]   <= '0;
                tgt_q[i]   <= '0;
                ctr_q[i]   <= WNT;
            end
        end else if (wr_en) begin
            valid_q[upd_idx] <= 1'b1;
            tag_q[upd_idx]   <= upd_tag;
            tgt_q[upd_idx]   <= wr_tgt_d;
            ctr_q[upd_idx]   <= wr_ctr_d;
        end
    end

    always_comb begin
        br_cnt_d   = br_cnt_q;
        miss_cnt_d = miss_cnt_q;
        if (i_upd_valid && (br_cnt_q != '1)) begin
            br_cnt_d = br_cnt_q + 16'd1;
        end
        if (o_mispredict && (miss_cnt_q != '1)) begin
            miss_cnt_d = miss_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            br_cnt_q   <= '0;
            miss_cnt_q <= '0;
        end else begin
            br_cnt_q   <= br_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign o_br_cnt   = br_cnt_q;
    assign o_miss_cnt = miss_cnt_q;

endmodule

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 SHALL have parameter IDX_W, default 4, meaning log2 of table entries (16 entries).
REQ-002 SHALL have port i_clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port i_rst  input  1  asynchronous reset, active-high.
REQ-004 SHALL have port i_pc_if  input  32  PC of the instruction being fetched.
REQ-005 SHALL have port o_pred_taken  output  1  prediction for i_pc_if; 1 means redirect fetch.
REQ-006 SHALL have port o_pred_target  output  32  next fetch PC; the predicted target if o_pred_taken, else i_pc_if+4.
REQ-007 SHALL have port i_upd_valid  input  1  a resolved control-flow instruction (B-type, JAL, JALR) is in MEM this cycle.
REQ-008 SHALL have port i_upd_pc  input  32  PC of the resolved instruction.
REQ-009 SHALL have port i_upd_taken  input  1  actual outcome, from the MEM-stage branch-resolution logic.
REQ-010 SHALL have port i_upd_target  input  32  actual taken target.
REQ-011 SHALL have port i_upd_pred_taken  input  1  prediction carried down the pipeline with the instruction.
REQ-012 SHALL have port i_upd_pred_target  input  32  predicted target carried down the pipeline.
REQ-013 SHALL have port o_mispredict  output  1  flush IF/ID/EX and redirect the PC.
REQ-014 SHALL have port o_redirect_pc  output  32  correct PC when o_mispredict is 1.
REQ-015 SHALL have port o_br_cnt  output  16  number of resolved updates, saturating.
REQ-016 SHALL have port o_miss_cnt  output  16  number of mispredictions, saturating.

Function
REQ-017 SHALL hold 2^IDX_W entries, each with valid, tag = pc[31:IDX_W+2], 32-bit target, and a 2-bit counter (00 SNT, 01 WNT, 10 WT, 11 ST). Index = pc[IDX_W+1:2].
REQ-018 SHALL compute the prediction combinationally: hit = valid and tag match; o_pred_taken = hit and counter[1]; o_pred_target = o_pred_taken ? entry target : i_pc_if+4. Latency is zero cycles.
REQ-019 SHALL compute o_mispredict = i_upd_valid and (i_upd_taken != i_upd_pred_taken, or both taken with i_upd_target != i_upd_pred_target). The output is combinational.
REQ-020 SHALL drive o_redirect_pc = i_upd_taken ? i_upd_target : i_upd_pc+4.
REQ-021 SHALL, on a rising edge with i_upd_valid and a hit, saturate the counter: increment if taken (11 stays 11), decrement if not taken (00 stays 00), and write target = i_upd_target when taken.
REQ-022 SHALL, on i_upd_valid with a miss and i_upd_taken=1, allocate the entry: valid=1, tag, target, counter=10. This overwrites any entry at that index.
REQ-023 SHALL NOT allocate on a miss with i_upd_taken=0.
REQ-024 SHALL, when the IF and update indices are equal in the same cycle, return the pre-update entry to IF; the new value is visible from the next cycle.
REQ-025 SHALL increment o_br_cnt on every i_upd_valid and o_miss_cnt on every o_mispredict, each saturating at 16'hFFFF.
REQ-026 SHALL leave the table and counters unchanged when i_upd_valid=0.
REQ-027 SHALL wrap PC+4 arithmetic modulo 2^32 (32'hFFFFFFFC+4 = 0).

Reset
REQ-028 SHALL, while i_rst=1 and regardless of the clock, clear all valid bits, set all counters to 01 and all targets to 0, and clear o_br_cnt and o_miss_cnt.
REQ-029 SHALL, after reset, produce o_pred_taken=0 and o_pred_target=i_pc_if+4 for every PC; o_mispredict follows REQ-019 combinationally.
REQ-030 SHALL discard an update in progress when reset asserts mid-operation; no partial entry is written.

Structure
REQ-031 SHALL take IDX_W default, the 2-bit counter encoding (enum SNT/WNT/WT/ST) and the opcode constants for B-type, JAL and JALR from the shared package branch_pred_pkg.
REQ-032 SHALL implement the saturating counter update as one sub-module, sat_counter2: current state + taken -> next state.
REQ-033 SHALL keep the table in flops (no RAM macro) so that the asynchronous reset applies to every entry.

Verification
REQ-034 Reset, then i_pc_if=0x100 -> o_pred_taken=0, o_pred_target=0x104, o_br_cnt=o_miss_cnt=0.
REQ-035 Update pc=0x100, taken=1, target=0x200, pred_taken=0 -> o_mispredict=1, o_redirect_pc=0x200; next cycle i_pc_if=0x100 gives o_pred_taken=1, o_pred_target=0x200.
REQ-036 Four not-taken updates at 0x100 from WT -> counter 10 goes to 01, 00, 00, 00 with no underflow; prediction becomes 0 after the first update.
REQ-037 Aliasing: allocate 0x100, then a taken update at 0x140 (same index, IDX_W=4) -> 0x100 now misses, 0x140 hits.
REQ-038 Same-cycle update and read of 0x100 -> the old prediction is returned that cycle and the new one the next cycle; pred_taken=1 with target 0x300 vs actual 0x200 -> o_mispredict=1.
REQ-039 Force o_miss_cnt to 0xFFFF via 65535 mispredicts, then one more -> stays 0xFFFF; i_rst pulse mid-cycle clears it asynchronously.
